// File: rtl/glb_stream_sink.sv
// Captures up to NUM_BLOCKS length-prefixed blocks from a GLB read stream into
// on-chip memory, with LFSR backpressure, overflow flag and registered readback.
module glb_stream_sink #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned NUM_BLOCKS  = 2,
  parameter int unsigned START_DELAY = 500,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  localparam int unsigned BLK_W  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1,
  localparam int unsigned CFG_W  = $clog2(NUM_BLOCKS) + 1,
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  input  logic                  bp_mode,
  input  logic [CFG_W-1:0]      num_blocks_cfg,
  output logic                  done,
  output logic                  overflow_err,
  input  logic [BLK_W-1:0]      rd_block,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] rd_size,
  output logic [2:0]            state_dbg
);

  // Word index must count past DEPTH for oversize blocks up to 2^DATA_WIDTH-1.
  localparam int unsigned IDX_A = (DATA_WIDTH + 1 > 17) ? DATA_WIDTH + 1 : 17;
  localparam int unsigned IDX_W = ($clog2(DEPTH) + 1 > IDX_A) ? $clog2(DEPTH) + 1 : IDX_A;
  localparam int unsigned DLY_W = $clog2(START_DELAY + 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_DELAY = 3'd2,
    S_HDR   = 3'd3,
    S_DATA  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Handshake: a word moves at the posedge where ready && valid; ready is
  // registered and data/valid are ignored whenever ready is low.
  state_e                state_q, state_d;
  logic [15:0]           lfsr_q, lfsr_d, lfsr_step;
  logic [DLY_W-1:0]      dly_q, dly_d;
  logic [BLK_W-1:0]      blk_q, blk_d;
  logic [CFG_W-1:0]      cnt_q, cnt_d, cfg_eff;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] cur_size_q, cur_size_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_size_q;
  logic                  xfer, blk_done, blk_last, hdr_ovf, idx_last, mem_we;

  logic [DATA_WIDTH-1:0] mem      [2**BLK_W][2**ADDR_W];
  logic [DATA_WIDTH-1:0] size_mem [2**BLK_W];

  assign xfer      = ready_q && valid;
  assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign blk_last  = (CFG_W'(blk_q) + CFG_W'(1)) == cnt_q;
  assign hdr_ovf   = 64'(data) > 64'(DEPTH);
  assign idx_last  = (idx_q + IDX_W'(1)) == IDX_W'(cur_size_q);
  assign mem_we    = xfer && (state_q == S_DATA) && (idx_q < IDX_W'(DEPTH));

  always_comb begin
    cfg_eff = num_blocks_cfg;
    if (num_blocks_cfg == '0) begin
      cfg_eff = CFG_W'(1);
    end else if (num_blocks_cfg > CFG_W'(NUM_BLOCKS)) begin
      cfg_eff = CFG_W'(NUM_BLOCKS);
    end
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    dly_d      = dly_q;
    blk_d      = blk_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    cur_size_d = cur_size_q;
    ovf_d      = ovf_q;
    blk_done   = 1'b0;
    if (state_q == S_HDR || state_q == S_DATA) lfsr_d = lfsr_step;
    case (state_q)
      S_IDLE: if (flush) state_d = S_ARMED;
      S_ARMED: begin
        if (!flush) begin
          state_d = S_DELAY;
          dly_d   = DLY_W'(START_DELAY);
          cnt_d   = cfg_eff;
          blk_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_DELAY: begin
        if (dly_q <= DLY_W'(1)) begin
          state_d = S_HDR;
          dly_d   = '0;
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end
      S_HDR: begin
        if (xfer) begin
          cur_size_d = data;
          idx_d      = '0;
          if (hdr_ovf) ovf_d = 1'b1;
          if (data == '0) blk_done = 1'b1;
          else            state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_last) blk_done = 1'b1;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (blk_done) begin
      if (blk_last) begin
        state_d = S_DONE;
      end else begin
        blk_d   = blk_q + BLK_W'(1);
        state_d = S_HDR;
      end
    end
    // Flush wins over everything; a transfer in this cycle is still stored.
    if (flush && state_q != S_IDLE) state_d = S_ARMED;
    ready_d = (state_d == S_HDR || state_d == S_DATA) && (!bp_mode || lfsr_d[0]);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lfsr_q     <= LFSR_SEED;
      dly_q      <= '0;
      blk_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      cur_size_q <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_size_q  <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      dly_q      <= dly_d;
      blk_q      <= blk_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      cur_size_q <= cur_size_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= mem[rd_block][rd_addr];
      rd_size_q  <= size_mem[rd_block];
    end
  end

  // Capture storage carries no reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (mem_we) mem[blk_q][idx_q[ADDR_W-1:0]] <= data;
    if (xfer && state_q == S_HDR) size_mem[blk_q] <= data;
  end

  assign ready        = ready_q;
  assign done         = done_q;
  assign overflow_err = ovf_q;
  assign rd_data      = rd_data_q;
  assign rd_size      = rd_size_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_glb_stream_sink.sv
// Bench for glb_stream_sink: block-list reference model, readback scoreboard,
// directed runs (delay, backpressure, empty/oversize blocks, flush, reset) plus random runs.
module tb_glb_stream_sink;
  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int NB = 2;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic [DW-1:0] data = '0;
  logic          valid = 1'b0;
  logic          ready;
  logic          bp_mode = 1'b0;
  logic [1:0]    num_blocks_cfg = 2'd1;
  logic          done;
  logic          overflow_err;
  logic [0:0]    rd_block = '0;
  logic [2:0]    rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] rd_size;
  logic [2:0]    state_dbg;

  glb_stream_sink #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_BLOCKS(NB), .START_DELAY(SD), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .data(data), .valid(valid), .ready(ready),
    .bp_mode(bp_mode), .num_blocks_cfg(num_blocks_cfg), .done(done),
    .overflow_err(overflow_err), .rd_block(rd_block), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_size(rd_size), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: what each block should hold, derived from the word list.
  logic [DW-1:0] m_mem [NB][DEPTH];
  bit            m_mem_ok [NB][DEPTH];
  logic [DW-1:0] m_size [NB];
  bit            m_size_ok [NB];
  bit            m_ovf;

  // Scoreboard entry: {chk_size, chk_data, size, data}
  logic [2*DW+1:0] exp_q[$];
  logic            rd_req = 1'b0;
  logic            rd_pend = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp_v, $time);
    end
  endtask

  always @(posedge clk) rd_pend <= rd_req;

  always @(negedge clk) begin
    logic [2*DW+1:0] e;
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected actual=readback expected=none t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (e[2*DW])   check("rd_data", 32'(rd_data), 32'(e[DW-1:0]));
        if (e[2*DW+1]) check("rd_size", 32'(rd_size), 32'(e[2*DW-1:DW]));
      end
    end
  end

  function automatic void model_apply(input logic [DW-1:0] w[$]);
    int p;
    int b;
    int hdr;
    p = 0;
    b = 0;
    while (p < w.size() && b < NB) begin
      hdr = int'(w[p]);
      m_size[b] = w[p];
      m_size_ok[b] = 1'b1;
      p++;
      if (hdr > DEPTH) m_ovf = 1'b1;
      for (int i = 0; i < hdr && p < w.size(); i++) begin
        if (i < DEPTH) begin
          m_mem[b][i] = w[p];
          m_mem_ok[b][i] = 1'b1;
        end
        p++;
      end
      b++;
    end
  endfunction

  function automatic void model_clear();
    for (int b = 0; b < NB; b++) begin
      m_size_ok[b] = 1'b0;
      for (int a = 0; a < DEPTH; a++) m_mem_ok[b][a] = 1'b0;
    end
  endfunction

  task automatic start_run(input int cfg_in, input bit bp);
    int lat;
    num_blocks_cfg = 2'(cfg_in);
    bp_mode = bp;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    check("rearm_done_clr", 32'(done), 0);
    check("rearm_ovf_clr", 32'(overflow_err), 0);
    if (!bp) begin
      while (!ready && lat < SD + 50) begin
        @(negedge clk);
        lat++;
      end
      check("start_latency", 32'(lat), 32'(SD));
    end
    @(posedge clk); #1;
  endtask

  task automatic send_words(input logic [DW-1:0] w[$], input bit rand_valid, input bit expect_done);
    int budget;
    bit acc;
    for (int i = 0; i < w.size(); i++) begin
      data = w[i];
      valid = rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
      budget = 0;
      acc = 1'b0;
      while (!acc && budget <= 500) begin
        @(negedge clk);
        if (ready && valid) begin
          acc = 1'b1;
        end else begin
          budget++;
          @(posedge clk); #1;
          valid = rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
      end
      check("word_accepted", 32'(acc), 1);
      if (!acc) begin
        valid = 1'b0;
        return;
      end
      check("done_early", 32'(done), 0);
      @(posedge clk); #1;
      valid = 1'b0;
    end
    if (expect_done) begin
      @(negedge clk);
      check("done_set", 32'(done), 1);
      check("ready_off_done", 32'(ready), 0);
    end
  endtask

  task automatic read_all();
    for (int b = 0; b < NB; b++) begin
      for (int a = 0; a < DEPTH; a++) begin
        if (m_mem_ok[b][a] || m_size_ok[b]) begin
          rd_block = 1'(b);
          rd_addr = 3'(a);
          rd_req = 1'b1;
          exp_q.push_back({m_size_ok[b], m_mem_ok[b][a], m_size[b], m_mem[b][a]});
          @(posedge clk); #1;
          rd_req = 1'b0;
        end
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_run(input int cfg_in, input bit bp, input logic [DW-1:0] w[$]);
    m_ovf = 1'b0;
    model_apply(w);
    start_run(cfg_in, bp);
    send_words(w, bp, 1'b1);
    check("overflow_err", 32'(overflow_err), 32'(m_ovf));
    read_all();
    check("done_hold", 32'(done), 1);
    check("ovf_sticky", 32'(overflow_err), 32'(m_ovf));
  endtask

  task automatic gen_blocks(input int nb, output logic [DW-1:0] w[$]);
    int hdr;
    w.delete();
    for (int b = 0; b < nb; b++) begin
      hdr = $urandom_range(0, 11);
      w.push_back(DW'(hdr));
      for (int i = 0; i < hdr; i++) w.push_back(DW'($urandom_range(0, 65535)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w[$];
    int cfg_in;
    model_clear();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ovf", 32'(overflow_err), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_rd_size", 32'(rd_size), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single block, no backpressure
    w.delete();
    w.push_back(16'd3); w.push_back(16'h11); w.push_back(16'h22); w.push_back(16'h33);
    do_run(1, 1'b0, w);

    // Two blocks under LFSR backpressure with random valid
    w.delete();
    w.push_back(16'd5);
    for (int i = 0; i < 5; i++) w.push_back(DW'($urandom_range(0, 65535)));
    w.push_back(16'd2);
    for (int i = 0; i < 2; i++) w.push_back(DW'($urandom_range(0, 65535)));
    do_run(2, 1'b1, w);

    // Empty first block
    w.delete();
    w.push_back(16'd0); w.push_back(16'd1); w.push_back(16'hBEEF);
    do_run(2, 1'b0, w);

    // Random runs, including cfg=0 and oversize headers
    for (int r = 0; r < 5; r++) begin
      cfg_in = $urandom_range(0, 2);
      gen_blocks((cfg_in == 0) ? 1 : cfg_in, w);
      do_run(cfg_in, ($urandom_range(0, 1) == 1), w);
    end

    // Oversize block: all words drained, first DEPTH kept, overflow sticky
    w.delete();
    w.push_back(16'd10);
    for (int i = 1; i <= 10; i++) w.push_back(DW'(i));
    do_run(1, 1'b0, w);

    // Flush mid-DATA with an in-flight word, then a fresh run
    start_run(1, 1'b0);
    w.delete();
    w.push_back(16'd5); w.push_back(16'h0C01);
    send_words(w, 1'b0, 1'b0);
    data = 16'h0C02;
    valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("inflight_ready", 32'(ready), 1);
    @(posedge clk); #1;
    valid = 1'b0;
    flush = 1'b0;
    w.push_back(16'h0C02);
    model_apply(w);
    w.delete();
    w.push_back(16'd2); w.push_back(16'h000A); w.push_back(16'h000B);
    do_run(1, 1'b0, w);

    // Asynchronous reset during DATA
    start_run(1, 1'b0);
    w.delete();
    w.push_back(16'd9); w.push_back(16'd1); w.push_back(16'd2);
    send_words(w, 1'b0, 1'b0);
    check("ovf_before_rst", 32'(overflow_err), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ready", 32'(ready), 0);
    check("async_rst_done", 32'(done), 0);
    check("async_rst_ovf", 32'(overflow_err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("idle_after_rst_ready", 32'(ready), 0);
    check("idle_after_rst_done", 32'(done), 0);
    @(posedge clk); #1;
    w.delete();
    w.push_back(16'd1); w.push_back(16'h5A5A);
    do_run(1, 1'b0, w);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
